// File: rtl/mem_stage.sv
`default_nettype none
//==============================================================================
// Module   : mem_stage
// Memory stage of the five-stage core: holds the EX instruction, waits for the
// data-SRAM response, extends load data and feeds write-back and decode.
// Optional feature macro: MS_LOAD_FORWARD_EN (forward load data to decode).
// Revision : 1.0
//==============================================================================

`ifndef WIDTH_ES_TO_MS_BUS
`define WIDTH_ES_TO_MS_BUS 75
`endif
`ifndef WIDTH_MS_TO_WS_BUS
`define WIDTH_MS_TO_WS_BUS 70
`endif
`ifndef WIDTH_MS_TO_DS_BUS
`define WIDTH_MS_TO_DS_BUS 39
`endif

module mem_stage (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            es_to_ms_valid,
    input  logic [`WIDTH_ES_TO_MS_BUS-1:0]  es_to_ms_bus,
    output logic                            ms_allow_in,
    input  logic                            data_sram_data_ok,
    input  logic [31:0]                     data_sram_rdata,
    input  logic                            ws_allow_in,
    output logic                            ms_to_ws_valid,
    output logic [`WIDTH_MS_TO_WS_BUS-1:0]  ms_to_ws_bus,
    output logic [`WIDTH_MS_TO_DS_BUS-1:0]  ms_to_ds_bus
);

    localparam logic [2:0] c_OP_LD_W  = 3'b000;
    localparam logic [2:0] c_OP_LD_B  = 3'b001;
    localparam logic [2:0] c_OP_LD_H  = 3'b010;
    localparam logic [2:0] c_OP_LD_BU = 3'b011;
    localparam logic [2:0] c_OP_LD_HU = 3'b100;

    logic [`WIDTH_ES_TO_MS_BUS-1:0] r_es_to_ms_bus;
    logic                           r_ms_valid;
    logic                           r_rdata_got;
    logic [31:0]                    r_rdata_buf;

    logic [31:0] w_pc;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic        w_res_from_mem;
    logic [2:0]  w_load_op;
    logic        w_mem_req;

    logic        w_ms_ready_go;
    logic        w_handoff;
    logic        w_capture;
    logic [31:0] w_load_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_final_result;
    logic [31:0] w_fwd_wdata;
    logic        w_fwd_pending;

    assign w_pc           = r_es_to_ms_bus[31:0];
    assign w_gr_we        = r_es_to_ms_bus[32];
    assign w_dest         = r_es_to_ms_bus[37:33];
    assign w_alu_result   = r_es_to_ms_bus[69:38];
    assign w_res_from_mem = r_es_to_ms_bus[70];
    assign w_load_op      = r_es_to_ms_bus[73:71];
    assign w_mem_req      = r_es_to_ms_bus[74];

    assign w_ms_ready_go  = !w_mem_req || r_rdata_got || data_sram_data_ok;
    assign ms_allow_in    = !r_ms_valid || (w_ms_ready_go && ws_allow_in);
    assign ms_to_ws_valid = r_ms_valid && w_ms_ready_go;
    assign w_handoff      = ms_to_ws_valid && ws_allow_in;

    // A response that arrives in the handoff cycle is consumed directly and never buffered.
    assign w_capture = data_sram_data_ok && r_ms_valid && w_mem_req && !r_rdata_got && !w_handoff;

    assign w_load_word = r_rdata_got ? r_rdata_buf : data_sram_rdata;

    always_comb begin
        w_byte = w_load_word[7:0];
        case (w_alu_result[1:0])
            2'd0:    w_byte = w_load_word[7:0];
            2'd1:    w_byte = w_load_word[15:8];
            2'd2:    w_byte = w_load_word[23:16];
            default: w_byte = w_load_word[31:24];
        endcase
    end

    assign w_half = w_alu_result[1] ? w_load_word[31:16] : w_load_word[15:0];

    always_comb begin
        w_load_data = w_load_word;
        case (w_load_op)
            c_OP_LD_W:  w_load_data = w_load_word;
            c_OP_LD_B:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_OP_LD_H:  w_load_data = {{16{w_half[15]}}, w_half};
            c_OP_LD_BU: w_load_data = {24'h0, w_byte};
            c_OP_LD_HU: w_load_data = {16'h0, w_half};
            default:    w_load_data = w_load_word;
        endcase
    end

    assign w_final_result = w_res_from_mem ? w_load_data : w_alu_result;

`ifdef MS_LOAD_FORWARD_EN
    assign w_fwd_wdata   = w_final_result;
    assign w_fwd_pending = r_ms_valid && w_res_from_mem && !w_ms_ready_go;
`else
    // Loads are never forwarded from here; decode must wait for write-back.
    assign w_fwd_wdata   = w_res_from_mem ? 32'h0 : w_final_result;
    assign w_fwd_pending = r_ms_valid && w_res_from_mem;
`endif

    assign ms_to_ws_bus = {w_final_result, w_dest, w_gr_we, w_pc};
    assign ms_to_ds_bus = {w_fwd_pending, r_ms_valid && w_gr_we, w_dest, w_fwd_wdata};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid     <= 1'b0;
            r_es_to_ms_bus <= '0;
            r_rdata_got    <= 1'b0;
            r_rdata_buf    <= 32'h0;
        end else begin
            if (ms_allow_in) begin
                r_ms_valid <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allow_in) begin
                r_es_to_ms_bus <= es_to_ms_bus;
            end
            if (w_handoff) begin
                r_rdata_got <= 1'b0;
                r_rdata_buf <= 32'h0;
            end else if (w_capture) begin
                r_rdata_got <= 1'b1;
                r_rdata_buf <= data_sram_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
//==============================================================================
// Module   : tb_mem_stage
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// instruction stream scored against a transaction-level reference model.
// Revision : 1.0
//==============================================================================

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_to_ms_valid;
    logic [74:0] es_to_ms_bus;
    logic        ms_allow_in;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allow_in;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] ms_to_ds_bus;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef MS_LOAD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic        res_mem;
        logic [2:0]  op;
        logic        mem_req;
        logic [31:0] rdata;
        logic [3:0]  delay;
    } instr_t;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allow_in       (ms_allow_in),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allow_in       (ws_allow_in),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_to_ds_bus      (ms_to_ds_bus)
    );

    always #5 clk = ~clk;

    function automatic instr_t mk(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                                  input logic [31:0] alu, input logic res_mem, input logic [2:0] op,
                                  input logic mem_req);
        instr_t t;
        t.pc = pc; t.gr_we = gr_we; t.dest = dest; t.alu = alu; t.res_mem = res_mem;
        t.op = op; t.mem_req = mem_req; t.rdata = 32'h0; t.delay = 4'd0;
        return t;
    endfunction

    function automatic logic [74:0] bus_of(input instr_t t);
        return {t.mem_req, t.op, t.res_mem, t.alu, t.dest, t.gr_we, t.pc};
    endfunction

    // Arithmetic view of load extension: shift, mask, then subtract the modulus when negative.
    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * (addr % 4))) & 32'hFF;
        h = (w >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd2:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd3:    return b;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_final(input instr_t t, input logic [31:0] w);
        return t.res_mem ? exp_load(t.op, t.alu, w) : t.alu;
    endfunction

    task automatic test_reset;
        logic [95:0] junk;
        junk = {$urandom, $urandom, $urandom};
        resetn = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = junk[74:0];
        data_sram_rdata = $urandom;
        data_sram_data_ok = 1'b1;
        ws_allow_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (ms_allow_in !== 1'b1) $display("FAIL reset_allow_in got %b exp 1", ms_allow_in); else n_pass++;
        n_checks++; if (ms_to_ws_valid !== 1'b0) $display("FAIL reset_ws_valid got %b exp 0", ms_to_ws_valid); else n_pass++;
        n_checks++; if (ms_to_ws_bus !== 70'h0) $display("FAIL reset_ws_bus got %h exp 0", ms_to_ws_bus); else n_pass++;
        n_checks++; if (ms_to_ds_bus !== 39'h0) $display("FAIL reset_ds_bus got %h exp 0", ms_to_ds_bus); else n_pass++;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        resetn = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b0) $display("FAIL idle_ws_valid got %b exp 0", ms_to_ws_valid); else n_pass++;
    endtask

    task automatic test_alu;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = bus_of(mk(32'h1c000000, 1'b1, 5'd5, 32'h12345678, 1'b0, 3'd0, 1'b0));
        ws_allow_in = 1'b1;
        #1;
        n_checks++; if (ms_allow_in !== 1'b1) $display("FAIL alu_allow_in got %b exp 1", ms_allow_in); else n_pass++;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b1) $display("FAIL alu_ws_valid got %b exp 1", ms_to_ws_valid); else n_pass++;
        n_checks++;
        if (ms_to_ws_bus !== {32'h12345678, 5'd5, 1'b1, 32'h1c000000})
            $display("FAIL alu_ws_bus got %h exp %h", ms_to_ws_bus, {32'h12345678, 5'd5, 1'b1, 32'h1c000000});
        else n_pass++;
        n_checks++;
        if (ms_to_ds_bus !== {1'b0, 1'b1, 5'd5, 32'h12345678})
            $display("FAIL alu_ds_bus got %h exp %h", ms_to_ds_bus, {1'b0, 1'b1, 5'd5, 32'h12345678});
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b0) $display("FAIL alu_drained got %b exp 0", ms_to_ws_valid); else n_pass++;
    endtask

    task automatic test_load_extract;
        logic [2:0]  ops  [4];
        logic [31:0] addrs[4];
        logic [31:0] words[4];
        logic [31:0] exps [4];
        ops[0] = 3'd1; addrs[0] = 32'h00001002; words[0] = 32'h80FF7F01; exps[0] = 32'hFFFFFFFF;
        ops[1] = 3'd3; addrs[1] = 32'h00001002; words[1] = 32'h80FF7F01; exps[1] = 32'h000000FF;
        ops[2] = 3'd2; addrs[2] = 32'h00002002; words[2] = 32'h80011234; exps[2] = 32'hFFFF8001;
        ops[3] = 3'd4; addrs[3] = 32'h00002000; words[3] = 32'h80011234; exps[3] = 32'h00001234;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            es_to_ms_valid = 1'b1;
            es_to_ms_bus = bus_of(mk(32'h1c000100 + i * 4, 1'b1, 5'd9, addrs[i], 1'b1, ops[i], 1'b1));
            ws_allow_in = 1'b1;
            data_sram_data_ok = 1'b0;
            @(negedge clk);
            es_to_ms_valid = 1'b0;
            data_sram_data_ok = 1'b1;
            data_sram_rdata = words[i];
            #1;
            n_checks++; if (ms_to_ws_valid !== 1'b1) $display("FAIL ld%0d_ws_valid got %b exp 1", i, ms_to_ws_valid); else n_pass++;
            n_checks++;
            if (ms_to_ws_bus[69:38] !== exps[i]) $display("FAIL ld%0d_result got %h exp %h", i, ms_to_ws_bus[69:38], exps[i]);
            else n_pass++;
        end
        @(negedge clk);
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_delayed;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = bus_of(mk(32'h1c000200, 1'b1, 5'd12, 32'h00003000, 1'b1, 3'd0, 1'b1));
        ws_allow_in = 1'b1;
        data_sram_data_ok = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            es_to_ms_valid = 1'b0;
            data_sram_rdata = $urandom;
            #1;
            n_checks++; if (ms_to_ws_valid !== 1'b0) $display("FAIL wait%0d_ws_valid got %b exp 0", c, ms_to_ws_valid); else n_pass++;
            n_checks++; if (ms_allow_in !== 1'b0) $display("FAIL wait%0d_allow_in got %b exp 0", c, ms_allow_in); else n_pass++;
            n_checks++; if (ms_to_ds_bus[38] !== 1'b1) $display("FAIL wait%0d_pending got %b exp 1", c, ms_to_ds_bus[38]); else n_pass++;
        end
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h0BADF00D;
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b1) $display("FAIL delayed_ws_valid got %b exp 1", ms_to_ws_valid); else n_pass++;
        n_checks++;
        if (ms_to_ws_bus[69:38] !== 32'h0BADF00D) $display("FAIL delayed_result got %h exp 0badf00d", ms_to_ws_bus[69:38]);
        else n_pass++;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_stall_buffer;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = bus_of(mk(32'h1c000300, 1'b1, 5'd3, 32'h00004004, 1'b1, 3'd0, 1'b1));
        ws_allow_in = 1'b1;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        ws_allow_in = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hCAFEBABE;
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b1) $display("FAIL stall_ready got %b exp 1", ms_to_ws_valid); else n_pass++;
        n_checks++; if (ms_allow_in !== 1'b0) $display("FAIL stall_allow_in got %b exp 0", ms_allow_in); else n_pass++;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        #1;
        n_checks++;
        if (ms_to_ws_bus[69:38] !== 32'hCAFEBABE) $display("FAIL stall_hold got %h exp cafebabe", ms_to_ws_bus[69:38]);
        else n_pass++;
        @(negedge clk);
        ws_allow_in = 1'b1;
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b1) $display("FAIL buf_ws_valid got %b exp 1", ms_to_ws_valid); else n_pass++;
        n_checks++;
        if (ms_to_ws_bus[69:38] !== 32'hCAFEBABE) $display("FAIL buf_result got %h exp cafebabe", ms_to_ws_bus[69:38]);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b0) $display("FAIL buf_drained got %b exp 0", ms_to_ws_valid); else n_pass++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = bus_of(mk(32'h00000100, 1'b1, 5'd1, 32'h0000000A, 1'b0, 3'd0, 1'b0));
        ws_allow_in = 1'b1;
        @(negedge clk);
        es_to_ms_bus = bus_of(mk(32'h00000104, 1'b1, 5'd2, 32'h0000000B, 1'b0, 3'd0, 1'b0));
        #1;
        n_checks++; if (ms_allow_in !== 1'b1) $display("FAIL b2b_allow_in got %b exp 1", ms_allow_in); else n_pass++;
        n_checks++;
        if (ms_to_ws_bus !== {32'h0000000A, 5'd1, 1'b1, 32'h00000100}) $display("FAIL b2b_first got %h", ms_to_ws_bus);
        else n_pass++;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b1) $display("FAIL b2b_second_valid got %b exp 1", ms_to_ws_valid); else n_pass++;
        n_checks++;
        if (ms_to_ws_bus !== {32'h0000000B, 5'd2, 1'b1, 32'h00000104}) $display("FAIL b2b_second got %h", ms_to_ws_bus);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_midwait;
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = bus_of(mk(32'h1c000400, 1'b1, 5'd7, 32'h00005000, 1'b1, 3'd0, 1'b1));
        ws_allow_in = 1'b1;
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        n_checks++; if (ms_to_ds_bus[38] !== 1'b1) $display("FAIL midwait_pending got %b exp 1", ms_to_ds_bus[38]); else n_pass++;
        #2;
        resetn = 1'b0;
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b0) $display("FAIL rst_ws_valid got %b exp 0", ms_to_ws_valid); else n_pass++;
        n_checks++; if (ms_allow_in !== 1'b1) $display("FAIL rst_allow_in got %b exp 1", ms_allow_in); else n_pass++;
        n_checks++; if (ms_to_ds_bus !== 39'h0) $display("FAIL rst_ds_bus got %h exp 0", ms_to_ds_bus); else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = $urandom;
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b0) $display("FAIL stray_ws_valid got %b exp 0", ms_to_ws_valid); else n_pass++;
        @(negedge clk);
        data_sram_data_ok = 1'b0;
        #1;
        n_checks++; if (ms_to_ws_valid !== 1'b0) $display("FAIL stray_after got %b exp 0", ms_to_ws_valid); else n_pass++;
        n_checks++; if (ms_allow_in !== 1'b1) $display("FAIL stray_allow_in got %b exp 1", ms_allow_in); else n_pass++;
    endtask

    function automatic instr_t gen_instr();
        instr_t t;
        int kind;
        kind = $urandom_range(0, 3);
        t = mk($urandom, 1'b1, 5'($urandom_range(0, 31)), $urandom, 1'b0, 3'd0, 1'b0);
        if (kind == 1 || kind == 2) begin
            t.res_mem = 1'b1;
            t.mem_req = 1'b1;
            t.op = 3'($urandom_range(0, 4));
        end else if (kind == 3) begin
            t.gr_we = 1'b0;
            t.mem_req = 1'b1;
        end
        t.rdata = $urandom;
        t.delay = 4'($urandom_range(0, 4));
        return t;
    endfunction

    // Model: one resident instruction, the cycle count since it entered, and whether its response came.
    task automatic test_random_stream;
        instr_t pres, cur;
        bit have_pres = 1'b0;
        bit m_valid = 1'b0;
        bit m_resp = 1'b0;
        int m_wait = 0;
        bit dok, ready, exp_allow, leave, enter;
        int n_out = 0, dut_out = 0, cyc = 0;
        logic [31:0] res;
        logic [31:0] exp_wdata;
        bit exp_pending;
        cur = '0;
        pres = '0;
        while (cyc < 600 && (cyc < 500 || m_valid || have_pres)) begin
            @(negedge clk);
            cyc++;
            if (!have_pres && cyc < 500 && $urandom_range(0, 3) != 0) begin
                pres = gen_instr();
                have_pres = 1'b1;
            end
            es_to_ms_valid = have_pres;
            es_to_ms_bus = have_pres ? bus_of(pres) : {11'h0, $urandom, $urandom};
            ws_allow_in = ($urandom_range(0, 3) != 0);
            dok = m_valid && cur.mem_req && !m_resp && (m_wait == int'(cur.delay));
            data_sram_rdata = dok ? cur.rdata : $urandom;
            data_sram_data_ok = dok || ((!m_valid || !cur.mem_req) && $urandom_range(0, 5) == 0);
            ready = m_valid && (!cur.mem_req || m_resp || dok);
            exp_allow = !m_valid || (ready && ws_allow_in);
            res = exp_final(cur, cur.rdata);
            #1;
            n_checks++;
            if (ms_allow_in !== exp_allow) $display("FAIL rnd_allow_in cyc %0d got %b exp %b", cyc, ms_allow_in, exp_allow);
            else n_pass++;
            n_checks++;
            if (ms_to_ws_valid !== ready) $display("FAIL rnd_ws_valid cyc %0d got %b exp %b", cyc, ms_to_ws_valid, ready);
            else n_pass++;
            if (ms_to_ws_valid && ws_allow_in) dut_out++;
            if (ready) begin
                n_checks++;
                if (ms_to_ws_bus !== {res, cur.dest, cur.gr_we, cur.pc})
                    $display("FAIL rnd_ws_bus cyc %0d got %h exp %h", cyc, ms_to_ws_bus, {res, cur.dest, cur.gr_we, cur.pc});
                else n_pass++;
            end
            if (m_valid) begin
                exp_pending = FWD ? (cur.res_mem && !ready) : cur.res_mem;
                n_checks++;
                if (ms_to_ds_bus[38:32] !== {exp_pending, cur.gr_we, cur.dest})
                    $display("FAIL rnd_ds_ctrl cyc %0d got %h exp %h", cyc, ms_to_ds_bus[38:32], {exp_pending, cur.gr_we, cur.dest});
                else n_pass++;
                if (!FWD || !cur.res_mem || ready) begin
                    exp_wdata = (!FWD && cur.res_mem) ? 32'h0 : res;
                    n_checks++;
                    if (ms_to_ds_bus[31:0] !== exp_wdata)
                        $display("FAIL rnd_ds_wdata cyc %0d got %h exp %h", cyc, ms_to_ds_bus[31:0], exp_wdata);
                    else n_pass++;
                end
            end
            leave = ready && ws_allow_in;
            enter = have_pres && exp_allow;
            if (leave) n_out++;
            if (enter) begin
                cur = pres;
                have_pres = 1'b0;
                m_valid = 1'b1;
                m_wait = 0;
                m_resp = 1'b0;
            end else if (leave) begin
                m_valid = 1'b0;
            end else if (m_valid) begin
                m_wait++;
                if (dok) m_resp = 1'b1;
            end
        end
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b0;
        n_checks++;
        if (m_valid || have_pres) $display("FAIL rnd_drain_timeout resident %b presented %b exp 0 0", m_valid, have_pres);
        else n_pass++;
        n_checks++;
        if (dut_out !== n_out) $display("FAIL rnd_handoff_count got %0d exp %0d", dut_out, n_out);
        else n_pass++;
    endtask

    initial begin
        resetn = 1'b0;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        ws_allow_in = 1'b1;
        test_reset;
        test_alu;
        test_load_extract;
        test_delayed;
        test_stall_buffer;
        test_back_to_back;
        test_reset_midwait;
        test_random_stream;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Fourth pipeline stage of the five-stage CPU core, between the execute stage and the write-back stage. It holds each execute-stage instruction in a pipeline register and waits for the data-SRAM response when the instruction issued a memory request. It extracts and extends load data (word, byte and halfword, signed and unsigned) and drives the 70-bit bus and valid signal that the write-back stage consumes. It also publishes a forwarding/hazard bus to decode.

## Interface
- No parameters; bus widths are fixed by the `WIDTH_ES_TO_MS_BUS` (75), `WIDTH_MS_TO_WS_BUS` (70) and `WIDTH_MS_TO_DS_BUS` (39) header macros.
- clk  in  1  core clock, all state on rising edge
- resetn  in  1  reset, asynchronous, active-low; clears all state immediately
- es_to_ms_valid  in  1  execute stage presents a valid instruction
- es_to_ms_bus  in  75  [31:0] pc, [32] gr_we, [37:33] dest, [69:38] alu_result (address for loads), [70] res_from_mem, [73:71] load_op (000 ld.w, 001 ld.b, 010 ld.h, 011 ld.bu, 100 ld.hu), [74] mem_req (a data-SRAM request was accepted in EX)
- ms_allow_in  out  1  this stage can accept an instruction this cycle
- data_sram_data_ok  in  1  one-cycle data-SRAM response strobe
- data_sram_rdata  in  32  response data, valid only with data_ok
- ws_allow_in  in  1  write-back stage can accept
- ms_to_ws_valid  out  1  output instruction valid
- ms_to_ws_bus  out  70  [31:0] pc, [32] gr_we, [37:33] dest, [69:38] final_result
- ms_to_ds_bus  out  39  [31:0] wdata, [36:32] dest, [37] we (valid && gr_we), [38] pending (valid && res_from_mem && !ms_ready_go)

## Operation
- Pipeline register es_to_ms_bus_r is loaded when es_to_ms_valid && ms_allow_in. Otherwise it holds its value; it is not cleared when idle.
- ms_valid is updated to es_to_ms_valid whenever ms_allow_in is high.
- Response capture:
  - A one-entry buffer rdata_buf and flag rdata_got capture data_sram_rdata when data_ok arrives while ms_valid && mem_req && !rdata_got && !(ms_to_ws_valid && ws_allow_in).
  - Both are cleared when the instruction leaves the stage.
- ms_ready_go = !mem_req || rdata_got || data_sram_data_ok.
- ms_allow_in = !ms_valid || (ms_ready_go && ws_allow_in).
- ms_to_ws_valid = ms_valid && ms_ready_go.
- Load data source: rdata_got ? rdata_buf : data_sram_rdata.
- Load extraction, with addr = alu_result[1:0]:
  - byte = word >> (8*addr)
  - half = word >> (16*addr[1]); addr[0] is ignored
  - ld.b / ld.h sign-extend; ld.bu / ld.hu zero-extend; ld.w passes the word unchanged
- final_result = res_from_mem ? extracted load data : alu_result.
- A stores has mem_req=1, gr_we=0: it waits for data_ok like a load, and its result is unused.

## Timing
- Reset values:
  - ms_valid=0, rdata_got=0, rdata_buf=0, es_to_ms_bus_r=0
  - ms_allow_in=1, ms_to_ws_valid=0, ms_to_ws_bus=0, ms_to_ds_bus=0
- Latency is one cycle when mem_req=0, or when data_ok arrives in the first cycle after entry. Otherwise it is one cycle plus the cycles spent waiting for data_ok.
- data_ok in the same cycle as the handoff to WB: the data is forwarded combinationally and is not buffered.
- data_ok while WB stalls: the data is buffered, and the stage stays ready. The next WB accept sends the buffered data.
- Back-to-back: a new instruction may enter in the same cycle the current one leaves.
- data_ok while !ms_valid or while mem_req=0 is ignored.
- Reset asserted mid-wait drops the instruction and its buffered data immediately.

## Configuration
- MS_LOAD_FORWARD_EN:
  - Defined: ms_to_ds_bus.wdata carries final_result, including load data once ms_ready_go is high.
  - Undefined: when res_from_mem=1, wdata = 0 and pending stays asserted for the instruction's whole residency in this stage (pending = valid && res_from_mem). This forces decode to stall until write-back.
  - Non-load forwarding is the same in both cases.

## Test plan
- ALU op pc=0x1c000000, dest=5, alu_result=0x12345678, mem_req=0, ws_allow_in=1 -> next cycle ms_to_ws_valid=1 and final_result=0x12345678; ms_to_ds_bus we=1, dest=5.
- ld.b at addr low bits 2, rdata=0x80FF7F01, data_ok in the cycle after entry -> final_result=0xFFFFFFFF. The same case as ld.bu -> 0x000000FF.
- ld.h at addr low bits 2, rdata=0x8001_1234 -> 0xFFFF8001. ld.hu at addr low bits 0 -> 0x00001234.
- ld.w with data_ok delayed 3 cycles -> ms_to_ws_valid=0 and ms_allow_in=0 for 3 cycles, pending=1; the result is emitted in the data_ok cycle.
- ld.w where data_ok=1 with rdata=0xCAFEBABE while ws_allow_in=0, then rdata changes to 0 -> once ws_allow_in=1, final_result=0xCAFEBABE.
- Assert resetn=0 mid-wait -> ms_valid, ms_to_ws_valid and ms_to_ds_bus are 0 immediately, ms_allow_in=1; a later stray data_ok is ignored.
